// File: rtl/nios_sys_pio_pkg.sv
// Shared constants for the interrupting input PIO: Avalon register
// addresses, edge-type encodings and the debounce counter width helper.
package nios_sys_pio_pkg;

    // Avalon word addresses of the register map.
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // Encodings of the EDGE_TYPE parameter.
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Width of a per-bit debounce counter that must count to cycles-1.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/nios_sys_pio_debounce.sv
// Single-bit debouncer: the output level follows the input only after the
// input has differed from it for DEBOUNCE_CYCLES consecutive clocks.
module nios_sys_pio_debounce
    import nios_sys_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    // Count clocks of disagreement; accept the new level on the last one.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (d_i != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = d_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and accepted level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign q_o = lvl_q;

endmodule

// File: rtl/nios_sys_pio_in_irq.sv
// Parametrised Avalon-MM input PIO with synchroniser, edge detection,
// write-1-to-clear edge capture, interrupt mask and level interrupt.
// Optional per-bit debounce is enabled by defining NIOS_SYS_PIO_DEBOUNCE_EN.
//
// Avalon slave protocol: there is no wait-request and no read strobe. A
// write happens on any clock with chipselect=1 and write_n=0 and always
// completes in that clock. readdata is registered every clock from the
// current address, so a read sees its data one clock after the address.
module nios_sys_pio_in_irq
    import nios_sys_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] IRQ_RESET_MASK  = '0,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] lvl_q;
    logic [WIDTH-1:0] rise, fall, edge_vec;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    // Upper writedata bits are intentionally ignored.
    logic unused_wd;
    assign unused_wd = ^writedata;

    // Metastability chain on the asynchronous pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef NIOS_SYS_PIO_DEBOUNCE_EN
    // One debouncer per input bit between the synchroniser and edge logic.
    for (genvar g = 0; g < WIDTH; g++) begin : g_db
        nios_sys_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .d_i   (sync_out[g]),
            .q_o   (lvl[g])
        );
    end
`else
    // Without debounce the level is the synchroniser output directly.
    localparam int unused_db_cycles = DEBOUNCE_CYCLES;
    assign lvl = sync_out;
`endif

    // Edge vector chosen by EDGE_TYPE from the level and its delayed copy.
    always_comb begin
        rise = lvl & ~lvl_q;
        fall = ~lvl & lvl_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_vec = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_vec = rise | fall;
        end else begin
            edge_vec = rise;
        end
    end

    assign wr_en = chipselect & ~write_n;

    // Register next-state: mask write, W1C capture (set wins), read mux.
    always_comb begin
        irqmask_d = irqmask_q;
        clr_bits  = '0;
        if (wr_en && address == PIO_ADDR_MASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == PIO_ADDR_EDGE) begin
            clr_bits = writedata[WIDTH-1:0];
        end
        edge_capture_d = (edge_capture_q & ~clr_bits) | edge_vec;

        readdata_d = '0;
        case (address)
            PIO_ADDR_DATA: readdata_d[WIDTH-1:0] = lvl;
            PIO_ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
            PIO_ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_capture_q;
            default:       readdata_d = '0;
        endcase
    end

    // State registers; edges seen on a reset clock are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q          <= '0;
            irqmask_q      <= IRQ_RESET_MASK;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            lvl_q          <= lvl;
            irqmask_q      <= irqmask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irqmask_q);

endmodule

// File: tb/tb_nios_sys_pio_in_irq.sv
// Bench for nios_sys_pio_in_irq: DUT A is the default 4-bit rising-edge
// port, DUT B is an 8-bit any-edge port with reset mask 0x80. Reads push
// {dut, irq, readdata} expectations; a negedge monitor pops and compares.
module tb_nios_sys_pio_in_irq;

`ifdef NIOS_SYS_PIO_DEBOUNCE_EN
  localparam int DB = 16;
  localparam int G  = 20;
`else
  localparam int DB = 0;
  localparam int G  = 2;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic [1:0]  cs;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;
  logic [3:0]  in_a;
  logic [7:0]  in_b;

  always #5 clk = ~clk;

  nios_sys_pio_in_irq u_a (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs[0]),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (rd_a),
    .in_port    (in_a),
    .irq        (irq_a)
  );

  nios_sys_pio_in_irq #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .EDGE_TYPE      (2),
    .IRQ_RESET_MASK (8'h80)
  ) u_b (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs[1]),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (rd_b),
    .in_port    (in_b),
    .irq        (irq_b)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  string       tag_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        rd_valid = 1'b0;
  logic [33:0] e;
  logic [32:0] got;
  string       t;

  always @(negedge clk) begin
    if (rd_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor: read presented with empty expected queue");
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got = e[33] ? {irq_b, rd_b} : {irq_a, rd_a};
        if (got !== e[32:0]) begin
          n_fail++;
          $display("FAIL %s: got irq=%0b rd=%08h, want irq=%0b rd=%08h",
                   t, got[32], got[31:0], e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One bus clock; optionally a write, optionally a checked read.
  task automatic cyc(input bit d, input logic [1:0] a, input bit we,
                     input logic [31:0] wd, input bit chk,
                     input logic [31:0] exp_rd, input bit exp_irq,
                     input string tg);
    address   = a;
    writedata = wd;
    write_n   = ~we;
    cs        = we ? (d ? 2'b10 : 2'b01) : 2'b00;
    if (chk) begin
      exp_q.push_back({d, exp_irq, exp_rd});
      tag_q.push_back(tg);
    end
    @(posedge clk); #1;
    write_n = 1'b1;
    cs      = 2'b00;
    if (chk) begin
      rd_valid = 1'b1;
      @(negedge clk); #1;
      rd_valid = 1'b0;
    end
  endtask

  task automatic rd(input bit d, input logic [1:0] a, input logic [31:0] x,
                    input bit xi, input string tg);
    cyc(d, a, 1'b0, 32'h0, 1'b1, x, xi, tg);
  endtask

  task automatic wr(input bit d, input logic [1:0] a, input logic [31:0] wd);
    cyc(d, a, 1'b1, wd, 1'b0, 32'h0, 1'b0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; address = 2'd0; cs = 2'b00; write_n = 1'b1;
    writedata = 32'h0; in_a = 4'hF; in_b = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state; input already high gives one late rising capture.
    rd(0, 2'd0, 32'h0, 0, "rst_data_first");
    idle(DB);
    rd(0, 2'd3, 32'h0, 0, "rst_edge_r2");
    rd(0, 2'd3, 32'h0, 0, "rst_edge_r3");
    rd(0, 2'd3, 32'hF, 0, "rst_edge_r4");
    rd(0, 2'd0, 32'hF, 0, "rst_data");
    rd(0, 2'd2, 32'h0, 0, "rst_mask");
    rd(1, 2'd2, 32'h80, 0, "b_rst_mask");
    rd(1, 2'd0, 32'h0, 0, "b_rst_data");
    rd(1, 2'd3, 32'h0, 0, "b_rst_edge");

    // W1C with read in the same clock returns the pre-clear value.
    cyc(0, 2'd3, 1'b1, 32'hF, 1'b1, 32'hF, 0, "w1c_preclear");
    rd(0, 2'd3, 32'h0, 0, "w1c_after");

    // Falling edges are not captured on a rising-edge port.
    in_a = 4'h0;
    idle(G + DB + 3);
    rd(0, 2'd3, 32'h0, 0, "no_fall_capture");

    // Rising capture latency and irq with mask 0x4.
    wr(0, 2'd2, 32'h4);
    in_a = 4'h4;
    rd(0, 2'd3, 32'h0, 0, "rise_k");
    idle(DB);
    rd(0, 2'd3, 32'h0, 0, "rise_k1");
    rd(0, 2'd3, 32'h0, 1, "rise_k2");
    rd(0, 2'd3, 32'h4, 1, "rise_k3");
    cyc(0, 2'd3, 1'b1, 32'h4, 1'b1, 32'h4, 0, "rise_clear");
    rd(0, 2'd3, 32'h0, 0, "rise_cleared");

    // Edge on bit 0 in the same clock as its W1C: set wins.
    wr(0, 2'd2, 32'h5);
    in_a = 4'h5;
    idle(G);
    in_a = 4'h4;
    idle(G);
    in_a = 4'h5;
    idle(2 + DB);
    cyc(0, 2'd3, 1'b1, 32'h1, 1'b1, 32'h1, 1, "setclr_same");
    rd(0, 2'd3, 32'h1, 1, "setclr_after");
    wr(0, 2'd3, 32'hF);

    // Any-edge port: rise captured, W1C, then fall captured again.
    in_b = 8'h80;
    idle(3 + DB);
    rd(1, 2'd3, 32'h80, 1, "b_rise");
    cyc(1, 2'd3, 1'b1, 32'h80, 1'b1, 32'h80, 0, "b_clear");
    in_b = 8'h00;
    idle(2 + DB);
    rd(1, 2'd3, 32'h0, 1, "b_fall_set");
    rd(1, 2'd3, 32'h80, 1, "b_fall_read");
    rd(1, 2'd1, 32'h0, 1, "b_reserved");
    wr(1, 2'd1, 32'hFFFF_FFFF);
    rd(1, 2'd1, 32'h0, 1, "b_reserved_wr");

    // Mask gating, then reset while captures are pending.
    wr(0, 2'd2, 32'h0);
    in_a = 4'h0;
    idle(G + DB + 3);
    in_a = 4'h3;
    idle(3 + DB);
    rd(0, 2'd3, 32'h3, 0, "gate_masked");
    cyc(0, 2'd2, 1'b1, 32'hFFFF_FFF2, 1'b1, 32'h0, 1, "gate_mask_wr");
    rd(0, 2'd2, 32'h2, 1, "gate_mask_read");

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd(0, 2'd3, 32'h0, 0, "midrst_edge");
    rd(0, 2'd2, 32'h0, 0, "midrst_mask");
    rd(1, 2'd2, 32'h80, 0, "midrst_b_mask");
    idle(DB);
    rd(0, 2'd3, 32'h3, 0, "midrst_recapture");
    wr(0, 2'd3, 32'hF);

`ifdef NIOS_SYS_PIO_DEBOUNCE_EN
    // Short glitch is filtered; a long hold is accepted after 16 clocks.
    in_a = 4'hB;
    idle(10);
    in_a = 4'h3;
    idle(30);
    rd(0, 2'd0, 32'h3, 0, "db_glitch_data");
    rd(0, 2'd3, 32'h0, 0, "db_glitch_edge");
    in_a = 4'hB;
    idle(17);
    rd(0, 2'd0, 32'h3, 0, "db_hold_before");
    rd(0, 2'd0, 32'hB, 0, "db_hold_data");
    rd(0, 2'd3, 32'h8, 0, "db_hold_edge");
`endif

    idle(3);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
